// File: rtl/uart_rx_param.sv
// Parametrised UART receive engine: 2-flop synchroniser, 3-sample majority
// vote, optional parity, 1 or 2 stop bits, framing/parity/break detection.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE - 2);
    localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE - 3);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_ON   = (PARITY_EN != 0);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state, state_nxt;

    logic                 sync1, rxs;
    logic [CW-1:0]        tick_cnt, tick_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [1:0]           smp;
    logic [DATA_BITS-1:0] shreg, sh_nxt;
    logic                 par_bit, par_nxt;
    logic                 ferr_acc, ferr_nxt;
    logic [DATA_BITS-1:0] dout_nxt;
    logic                 valid_nxt, perr_nxt, fo_nxt, brk_nxt;
    logic                 voted, last_tick, frame_bad, par_calc;

    assign voted     = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
    assign last_tick = s_tick && (tick_cnt == CNT_LAST);
    assign frame_bad = ferr_acc | ~voted;
    assign par_calc  = (^shreg) ^ PAR_ODD;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    // First two votes are captured here; the third is the live rxs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp <= 2'b11;
        end else begin
            if (s_tick && tick_cnt == CNT_S0) smp[0] <= rxs;
            if (s_tick && tick_cnt == CNT_S1) smp[1] <= rxs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            ferr_acc   <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            bit_cnt    <= bit_nxt;
            shreg      <= sh_nxt;
            par_bit    <= par_nxt;
            ferr_acc   <= ferr_nxt;
            dout       <= dout_nxt;
            dout_valid <= valid_nxt;
            parity_err <= perr_nxt;
            frame_err  <= fo_nxt;
            break_det  <= brk_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = s_tick ? tick_cnt + CW'(1) : tick_cnt;
        bit_nxt   = bit_cnt;
        sh_nxt    = shreg;
        par_nxt   = par_bit;
        ferr_nxt  = ferr_acc;
        dout_nxt  = dout;
        perr_nxt  = parity_err;
        fo_nxt    = frame_err;
        valid_nxt = 1'b0;
        brk_nxt   = 1'b0;

        unique case (state)
            S_IDLE: begin
                tick_nxt = '0;
                if (s_tick && !rxs) state_nxt = S_START;
            end
            S_START: begin
                if (s_tick && tick_cnt == CNT_MID)
                    state_nxt = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (last_tick) begin
                    sh_nxt   = {voted, shreg[DATA_BITS-1:1]};
                    bit_nxt  = bit_cnt + BW'(1);
                    tick_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = PAR_ON ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (last_tick) begin
                    par_nxt   = voted;
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (last_tick) begin
                    ferr_nxt = frame_bad;
                    bit_nxt  = bit_cnt + BW'(1);
                    tick_nxt = '0;
                    if (bit_cnt == STP_LAST) begin
                        bit_nxt   = '0;
                        ferr_nxt  = 1'b0;
                        dout_nxt  = shreg;
                        perr_nxt  = PAR_ON && (par_bit != par_calc);
                        fo_nxt    = frame_bad;
                        valid_nxt = 1'b1;
                        // All-zero frame with a low stop bit is a held-low line.
                        if (frame_bad && shreg == '0 && !(PAR_ON && par_bit)) begin
                            brk_nxt   = 1'b1;
                            state_nxt = S_BREAK;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
            end
            S_BREAK: begin
                tick_nxt = '0;
                if (s_tick && rxs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (state_nxt != state) tick_nxt = '0;
    end

endmodule
